// File: rtl/muldiv_ctrl_if.sv
// muldiv_ctrl_if: handshake between the EX-stage M-extension controller and
// the iterative multiply/divide unit.
//   md_start_o   ctrl -> unit  one-cycle start pulse
//   md_op_o      ctrl -> unit  RV32M funct3 of the operation
//   md_a_o/b_o   ctrl -> unit  operands, held stable while the unit works
//   md_kill_o    ctrl -> unit  one-cycle abort pulse
//   md_done_i    unit -> ctrl  completion strobe
//   md_result_i  unit -> ctrl  result, valid with md_done_i
`timescale 1ns/1ps
interface muldiv_ctrl_if;
   logic        md_start_o;
   logic [2:0]  md_op_o;
   logic [31:0] md_a_o;
   logic [31:0] md_b_o;
   logic        md_kill_o;
   logic        md_done_i;
   logic [31:0] md_result_i;

   modport master (
      output md_start_o, md_op_o, md_a_o, md_b_o, md_kill_o,
      input  md_done_i, md_result_i
   );

   modport slave (
      input  md_start_o, md_op_o, md_a_o, md_b_o, md_kill_o,
      output md_done_i, md_result_i
   );
endinterface

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: sequences one RV32M instruction in EX through an iterative
// mul/div unit. Stalls the front of the pipe while the unit works, resolves
// divide-by-zero and signed-overflow cases locally, and aborts on a watchdog.
//   clk, rst_n           clock, asynchronous active-low reset
//   ex_is_muldiv_i       nonzero = M-extension instruction in EX
//   ex_funct3_i          RV32M operation
//   ex_rs1/rs2_val_i     forwarded operands
//   ex_rd_addr_i         destination register
//   flush_i              EX-stage flush
//   md                   unit handshake (muldiv_ctrl_if.master)
//   stall_o              holds IF/ID and ID/EX
//   result_valid_o       one-cycle writeback strobe with result_o/result_rd_o
//   timeout_o            one-cycle pulse on watchdog abort
//
// state | meaning
// IDLE  | waiting for an M instruction in EX
// ISSUE | start pulse to the unit, watchdog armed
// WAIT  | unit busy; done, flush or watchdog expiry leaves
// DONE  | result presented for one cycle, instruction leaves EX
`timescale 1ns/1ps
module muldiv_ctrl #(
   parameter int TIMEOUT = 64
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [1:0]          ex_is_muldiv_i,
   input  logic [2:0]          ex_funct3_i,
   input  logic [31:0]         ex_rs1_val_i,
   input  logic [31:0]         ex_rs2_val_i,
   input  logic [4:0]          ex_rd_addr_i,
   input  logic                flush_i,
   muldiv_ctrl_if.master       md,
   output logic                stall_o,
   output logic                result_valid_o,
   output logic [31:0]         result_o,
   output logic [4:0]          result_rd_o,
   output logic                timeout_o
);
   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   state_t      state_q, state_d;
   logic [2:0]  op_q, op_d;
   logic [31:0] a_q, a_d;
   logic [31:0] b_q, b_d;
   logic [4:0]  rd_q, rd_d;
   logic [31:0] res_q, res_d;
   logic [CW-1:0] wdog_q, wdog_d;
   logic        start_c, kill_c;

   logic req, is_div, div_zero, div_ovf;

   assign req      = (ex_is_muldiv_i != 2'b00) && !flush_i;
   assign is_div   = ex_funct3_i[2];
   assign div_zero = is_div && (ex_rs2_val_i == 32'd0);
   // signed DIV/REM only (funct3[0] clear)
   assign div_ovf  = is_div && !ex_funct3_i[0] &&
                     (ex_rs1_val_i == 32'h8000_0000) && (ex_rs2_val_i == 32'hFFFF_FFFF);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         rd_q    <= '0;
         res_q   <= '0;
         wdog_q  <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         rd_q    <= rd_d;
         res_q   <= res_d;
         wdog_q  <= wdog_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      op_d           = op_q;
      a_d            = a_q;
      b_d            = b_q;
      rd_d           = rd_q;
      res_d          = res_q;
      wdog_d         = wdog_q;
      start_c        = 1'b0;
      kill_c         = 1'b0;
      stall_o        = 1'b0;
      result_valid_o = 1'b0;
      timeout_o      = 1'b0;

      case (state_q)
         IDLE: begin
            if (req) begin
               stall_o = 1'b1;
               op_d    = ex_funct3_i;
               a_d     = ex_rs1_val_i;
               b_d     = ex_rs2_val_i;
               rd_d    = ex_rd_addr_i;
               if (div_zero) begin
                  res_d   = ex_funct3_i[1] ? ex_rs1_val_i : 32'hFFFF_FFFF;
                  state_d = DONE;
               end else if (div_ovf) begin
                  res_d   = ex_funct3_i[1] ? 32'd0 : 32'h8000_0000;
                  state_d = DONE;
               end else begin
                  state_d = ISSUE;
               end
            end
         end

         ISSUE: begin
            if (flush_i) begin
               kill_c  = 1'b1;
               state_d = IDLE;
            end else begin
               start_c = 1'b1;
               stall_o = 1'b1;
               wdog_d  = CW'(TIMEOUT - 1);
               state_d = WAIT;
            end
         end

         WAIT: begin
            if (flush_i) begin
               kill_c  = 1'b1;
               state_d = IDLE;
            end else if (md.md_done_i) begin
               stall_o = 1'b1;
               res_d   = md.md_result_i;
               state_d = DONE;
            end else if (wdog_q == '0) begin
               // watchdog terminal count: this is the TIMEOUT-th WAIT cycle
               stall_o   = 1'b1;
               timeout_o = 1'b1;
               kill_c    = 1'b1;
               res_d     = 32'd0;
               state_d   = DONE;
            end else begin
               stall_o = 1'b1;
               wdog_d  = wdog_q - CW'(1);
            end
         end

         DONE: begin
            result_valid_o = !flush_i;
            state_d        = IDLE;
         end

         default: state_d = IDLE;
      endcase
   end

   assign md.md_start_o = start_c;
   assign md.md_kill_o  = kill_c;
   assign md.md_op_o    = op_q;
   assign md.md_a_o     = a_q;
   assign md.md_b_o     = b_q;
   assign result_o      = res_q;
   assign result_rd_o   = rd_q;
endmodule

// File: tb/tb_muldiv_ctrl.sv
`timescale 1ns/1ps
module tb_muldiv_ctrl;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [1:0]  ex_is_muldiv = '0;
   logic [2:0]  ex_funct3 = '0;
   logic [31:0] ex_rs1 = '0, ex_rs2 = '0;
   logic [4:0]  ex_rd = '0;
   logic        flush = 1'b0;

   logic        stall, rvalid, tmo;
   logic [31:0] result;
   logic [4:0]  rrd;
   logic        stall8, rvalid8, tmo8;
   logic [31:0] result8;
   logic [4:0]  rrd8;

   muldiv_ctrl_if md_if();
   muldiv_ctrl_if md8_if();
   assign md8_if.md_done_i   = 1'b0;
   assign md8_if.md_result_i = 32'd0;

   muldiv_ctrl u_dut (
      .clk(clk), .rst_n(rst_n), .ex_is_muldiv_i(ex_is_muldiv), .ex_funct3_i(ex_funct3),
      .ex_rs1_val_i(ex_rs1), .ex_rs2_val_i(ex_rs2), .ex_rd_addr_i(ex_rd), .flush_i(flush),
      .md(md_if.master), .stall_o(stall), .result_valid_o(rvalid), .result_o(result),
      .result_rd_o(rrd), .timeout_o(tmo)
   );

   muldiv_ctrl #(.TIMEOUT(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .ex_is_muldiv_i(ex_is_muldiv), .ex_funct3_i(ex_funct3),
      .ex_rs1_val_i(ex_rs1), .ex_rs2_val_i(ex_rs2), .ex_rd_addr_i(ex_rd), .flush_i(flush),
      .md(md8_if.master), .stall_o(stall8), .result_valid_o(rvalid8), .result_o(result8),
      .result_rd_o(rrd8), .timeout_o(tmo8)
   );

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // scoreboard of {rd, result} expected from the default-TIMEOUT instance
   logic [36:0] sb_q[$];

   // behavioural iterative unit: done strobes unit_lat cycles after start
   int          unit_lat = 0;
   logic [31:0] unit_res = '0;
   int          unit_cnt = 0;
   int          start_cnt = 0;
   logic [2:0]  cap_op;
   logic [31:0] cap_a, cap_b;

   always @(negedge clk) begin
      if (rst_n) begin
         if (md_if.md_start_o) begin
            start_cnt++;
            unit_cnt = unit_lat;
            cap_op = md_if.md_op_o;
            cap_a  = md_if.md_a_o;
            cap_b  = md_if.md_b_o;
         end
         if (md_if.md_kill_o) unit_cnt = 0;
         if (rvalid) begin
            if (sb_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_result: got rd=%0d res=%0h expected no result_valid", rrd, result);
            end else begin
               logic [36:0] e;
               e = sb_q.pop_front();
               check("result", {35'd0, rrd, result}, {35'd0, e});
            end
         end
      end
   end

   always @(posedge clk) begin
      #1;
      if (!rst_n) begin
         unit_cnt = 0;
         md_if.md_done_i = 1'b0;
      end else begin
         md_if.md_done_i = 1'b0;
         if (unit_cnt > 0) begin
            unit_cnt--;
            if (unit_cnt == 0) begin
               md_if.md_done_i   = 1'b1;
               md_if.md_result_i = unit_res;
               check("operand_hold", {5'd0, md_if.md_op_o, md_if.md_a_o, md_if.md_b_o},
                     {5'd0, cap_op, cap_a, cap_b});
            end
         end
      end
   end

   typedef struct {
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  rd;
      int          lat;
      logic [31:0] unit_res;
      logic [31:0] exp;
      bit          shortcut;
   } vec_t;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd);
      ex_is_muldiv = rd[0] ? 2'b01 : 2'b10;
      ex_funct3    = f3;
      ex_rs1       = a;
      ex_rs2       = b;
      ex_rd        = rd;
   endtask

   task automatic idle_in();
      ex_is_muldiv = 2'b00;
      flush        = 1'b0;
   endtask

   // Called just after a rising edge; returns just after the edge that
   // follows DONE, with the request still driven.
   task automatic apply_vec(input vec_t v, input int idx);
      int s0;
      int n;
      s0       = start_cnt;
      unit_lat = v.lat;
      unit_res = v.unit_res;
      drive(v.f3, v.a, v.b, v.rd);
      sb_q.push_back({v.rd, v.exp});
      @(negedge clk);
      check($sformatf("stall_req[%0d]", idx), {71'd0, stall}, 72'd1);
      n = 0;
      while (stall && n < 100) begin
         cyc();
         @(negedge clk);
         n++;
      end
      check($sformatf("latency[%0d]", idx), 72'(n), v.shortcut ? 72'd1 : 72'(v.lat + 2));
      check($sformatf("starts[%0d]", idx), 72'(start_cnt - s0), v.shortcut ? 72'd0 : 72'd1);
      check($sformatf("valid_done[%0d]", idx), {71'd0, rvalid}, 72'd1);
      cyc();
   endtask

   vec_t vecs[14];

   initial begin
      int s0;
      int n;
      vec_t v;
      vecs[0]  = '{3'b101, 32'd100,        32'd7,          5'd3,  33, 32'd14,         32'd14,         1'b0};
      vecs[1]  = '{3'b100, 32'd5,          32'd0,          5'd4,  0,  32'd0,          32'hFFFF_FFFF,  1'b1};
      vecs[2]  = '{3'b110, 32'd5,          32'd0,          5'd5,  0,  32'd0,          32'd5,          1'b1};
      vecs[3]  = '{3'b101, 32'd9,          32'd0,          5'd6,  0,  32'd0,          32'hFFFF_FFFF,  1'b1};
      vecs[4]  = '{3'b111, 32'd9,          32'd0,          5'd7,  0,  32'd0,          32'd9,          1'b1};
      vecs[5]  = '{3'b100, 32'h8000_0000,  32'hFFFF_FFFF,  5'd8,  0,  32'd0,          32'h8000_0000,  1'b1};
      vecs[6]  = '{3'b110, 32'h8000_0000,  32'hFFFF_FFFF,  5'd9,  0,  32'd0,          32'd0,          1'b1};
      vecs[7]  = '{3'b101, 32'h8000_0000,  32'hFFFF_FFFF,  5'd10, 2,  32'd0,          32'd0,          1'b0};
      vecs[8]  = '{3'b111, 32'h8000_0000,  32'hFFFF_FFFF,  5'd11, 1,  32'h8000_0000,  32'h8000_0000,  1'b0};
      vecs[9]  = '{3'b000, 32'd3,          32'd4,          5'd12, 1,  32'd12,         32'd12,         1'b0};
      vecs[10] = '{3'b001, 32'h7FFF_FFFF,  32'd2,          5'd13, 5,  32'd0,          32'd0,          1'b0};
      vecs[11] = '{3'b010, 32'hFFFF_FFFF,  32'd2,          5'd14, 3,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0};
      vecs[12] = '{3'b100, 32'd20,         32'hFFFF_FFFD,  5'd15, 4,  32'hFFFF_FFFA,  32'hFFFF_FFFA,  1'b0};
      vecs[13] = '{3'b011, 32'd5,          32'd0,          5'd31, 1,  32'd0,          32'd0,          1'b0};

      md_if.md_done_i   = 1'b0;
      md_if.md_result_i = '0;

      // reset state
      repeat (2) @(negedge clk);
      check("reset_ctl", {64'd0, md_if.md_start_o, md_if.md_kill_o, tmo, rvalid, stall, md_if.md_op_o},
            72'd0);
      check("reset_data", {md_if.md_a_o, md_if.md_b_o, 8'd0}, 72'd0);
      check("reset_result", {35'd0, rrd, result}, 72'd0);

      // first request right on the first edge after release, then all vectors back-to-back
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 14; i++) apply_vec(vecs[i], i);
      idle_in();
      repeat (3) cyc();

      // flush in WAIT coincident with md_done_i
      s0       = start_cnt;
      unit_lat = 3;
      unit_res = 32'd99;
      drive(3'b000, 32'd6, 32'd7, 5'd20);
      repeat (4) cyc();
      flush = 1'b1;
      @(negedge clk);
      check("flush_done_coincide", {71'd0, md_if.md_done_i}, 72'd1);
      check("flush_kill", {69'd0, md_if.md_kill_o, stall, rvalid}, 72'b100);
      check("flush_starts", 72'(start_cnt - s0), 72'd1);
      cyc();
      idle_in();
      @(negedge clk);
      check("flush_idle", {68'd0, md_if.md_kill_o, md_if.md_start_o, stall, rvalid}, 72'd0);
      cyc();
      @(negedge clk);
      check("flush_no_reissue", 72'(start_cnt - s0), 72'd1);

      // flush in DONE suppresses result_valid
      cyc();
      s0 = start_cnt;
      drive(3'b100, 32'd5, 32'd0, 5'd21);
      @(negedge clk);
      check("fdone_stall", {71'd0, stall}, 72'd1);
      cyc();
      flush = 1'b1;
      @(negedge clk);
      check("fdone_suppress", {70'd0, rvalid, stall}, 72'd0);
      cyc();
      idle_in();
      @(negedge clk);
      check("fdone_after", {70'd0, rvalid, 72'(start_cnt - s0) != 72'd0}, 72'd0);

      // watchdog: TIMEOUT=8 instance, unit never answers
      repeat (12) cyc();
      unit_lat = 0;
      drive(3'b000, 32'd1, 32'd1, 5'd22);
      sb_q.push_back({5'd22, 32'd0});
      @(negedge clk);
      check("tmo_stall", {71'd0, stall8}, 72'd1);
      cyc();
      idle_in();
      for (int k = 1; k <= 8; k++) begin
         cyc();
         @(negedge clk);
         check($sformatf("tmo_wait[%0d]", k), {70'd0, tmo8, md8_if.md_kill_o},
               (k == 8) ? 72'b11 : 72'b00);
      end
      cyc();
      @(negedge clk);
      check("tmo_valid", {71'd0, rvalid8}, 72'd1);
      check("tmo_result", {35'd0, rrd8, result8}, {35'd0, 5'd22, 32'd0});
      cyc();
      @(negedge clk);
      check("tmo_valid_once", {71'd0, rvalid8}, 72'd0);
      n = 0;
      while (sb_q.size() != 0 && n < 100) begin
         cyc();
         n++;
      end
      check("default_timeout_drained", 72'(sb_q.size()), 72'd0);

      // MUL then MULHU back-to-back, reset mid-WAIT of the MULHU
      idle_in();
      repeat (3) cyc();
      v = '{3'b000, 32'd3, 32'd7, 5'd23, 2, 32'd21, 32'd21, 1'b0};
      apply_vec(v, 100);
      unit_lat = 20;
      drive(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd24);
      repeat (4) cyc();
      #2;
      rst_n = 1'b0;
      ex_is_muldiv = 2'b00;
      #1;
      check("rst_wait_ctl", {64'd0, md_if.md_start_o, md_if.md_kill_o, tmo, rvalid, stall, md_if.md_op_o},
            72'd0);
      check("rst_wait_data", {md_if.md_a_o, md_if.md_b_o, 8'd0}, 72'd0);
      check("rst_wait_result", {35'd0, rrd, result}, 72'd0);
      repeat (2) @(negedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      v = '{3'b000, 32'd2, 32'd3, 5'd25, 1, 32'd6, 32'd6, 1'b0};
      apply_vec(v, 101);
      idle_in();
      repeat (3) cyc();
      check("scoreboard_empty", 72'(sb_q.size()), 72'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got simulation still running expected finish");
      $fatal(1);
   end
endmodule
